// File: rtl/nibble_serial_addsub_ctrl_if.sv
// nibble_serial_addsub_ctrl_if: request side (start, op, a, b) and result side (busy, done, result, carry_out, overflow, zero) of the add/sub controller
interface nibble_serial_addsub_ctrl_if #(parameter int NIBBLES = 4) ();
  logic start;
  logic op;
  logic [4*NIBBLES-1:0] a;
  logic [4*NIBBLES-1:0] b;
  logic busy;
  logic done;
  logic [4*NIBBLES-1:0] result;
  logic carry_out;
  logic overflow;
  logic zero;
  modport master (output start, op, a, b, input busy, done, result, carry_out, overflow, zero);
  modport slave (input start, op, a, b, output busy, done, result, carry_out, overflow, zero);
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl: wide add/sub via one 4-bit slice over NIBBLES cycles, LS nibble first; ports clk, reset (async high), bus (slave: start/op/a/b in, busy/done/result/carry_out/overflow/zero out)
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic clk,
  input logic reset,
  nibble_serial_addsub_ctrl_if.slave bus
);
  localparam int W = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, result_q, result_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, carry_out_q, carry_out_d, overflow_q, overflow_d, zero_q, zero_d;
  logic [4:0] sum;
  logic [W+3:0] wide;
  logic accept, run, last;
  always_comb begin
    sum = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + 5'(carry_q);
    wide = {sum[3:0], sh_q};
    accept = state_q == IDLE && bus.start;
    run = state_q == RUN;
    last = run && idx_q == IW'(NIBBLES - 1);
    state_d = accept ? RUN : last ? DONE : state_q == DONE ? IDLE : state_q;
    a_d = accept ? bus.a : run ? a_q >> 4 : a_q;
    b_d = accept ? bus.b ^ {W{bus.op}} : run ? b_q >> 4 : b_q;
    carry_d = accept ? bus.op : run ? sum[4] : carry_q;
    idx_d = accept ? '0 : run ? idx_q + IW'(1) : idx_q;
    sh_d = accept ? '0 : run ? wide[W+3:4] : sh_q;
    result_d = last ? wide[W+3:4] : result_q;
    carry_out_d = last ? sum[4] : carry_out_q;
    overflow_d = last ? (a_q[3] == b_q[3]) && (sum[3] != a_q[3]) : overflow_q;
    zero_d = last ? wide[W+3:4] == '0 : zero_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sh_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
      result_q <= '0;
      carry_out_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sh_q <= sh_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      result_q <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q <= overflow_d;
      zero_q <= zero_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.result = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow = overflow_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// tb_nibble_serial_addsub_ctrl: vector table, randomized model comparison and multi-cycle corner sequences
module tb_nibble_serial_addsub_ctrl;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  nibble_serial_addsub_ctrl_if #(.NIBBLES(N)) bus ();
  nibble_serial_addsub_ctrl #(.NIBBLES(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic op;
    logic [W-1:0] r;
    logic c;
    logic v;
    logic z;
  } vec_t;
  vec_t tbl[10];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                                output logic [W-1:0] r, output logic c, output logic v, output logic z);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint exact = op ? sa - sb : sa + sb;
    r = op ? a - b : a + b;
    c = op ? ua >= ub : (ua + ub) > 65535;
    v = exact > 32767 || exact < -32768;
    z = r == '0;
  endfunction
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic jam,
                        output logic [W-1:0] r, output logic c, output logic v, output logic z);
    logic [W-1:0] prev;
    bit seen;
    prev = bus.result;
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.op = op;
    step();
    bus.start = jam;
    bus.a = jam ? 16'hFFFF : W'($urandom);
    bus.b = W'($urandom);
    bus.op = 1'($urandom);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    check("done_after_accept", 32'(bus.done), 32'd0);
    seen = 0;
    for (int e = 1; e <= N + 2 && !seen; e++) begin
      step();
      if (bus.done) begin
        seen = 1;
        bus.start = 1'b0;
        check("done_latency", 32'(e), 32'(N));
        check("busy_in_done", 32'(bus.busy), 32'd1);
      end else begin
        check("busy_in_run", 32'(bus.busy), 32'd1);
        check("result_hold_in_run", 32'(bus.result), 32'(prev));
      end
    end
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout actual=none expected=done");
    end
    bus.start = 1'b0;
    r = bus.result;
    c = bus.carry_out;
    v = bus.overflow;
    z = bus.zero;
    step();
    check("done_pulse_end", 32'(bus.done), 32'd0);
    check("busy_end", 32'(bus.busy), 32'd0);
  endtask
  task automatic cmp(input string tag, input logic [W-1:0] r, input logic c, input logic v, input logic z,
                     input logic [W-1:0] er, input logic ec, input logic ev, input logic ez);
    check({tag, "_result"}, 32'(r), 32'(er));
    check({tag, "_carry"}, 32'(c), 32'(ec));
    check({tag, "_ovf"}, 32'(v), 32'(ev));
    check({tag, "_zero"}, 32'(z), 32'(ez));
  endtask
  initial begin
    logic [W-1:0] r, er, hr, ra, rb;
    logic c, v, z, ec, ev, ez, hc, hv, hz, ro;
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{16'h0003, 16'h0003, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = 1'b0;
    reset = 1'b1;
    step();
    step();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    cmp("rst", bus.result, bus.carry_out, bus.overflow, bus.zero, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].op, 1'b0, r, c, v, z);
      cmp($sformatf("vec%0d", i), r, c, v, z, tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].z);
    end
    run_op(16'h1234, 16'h1111, 1'b0, 1'b1, r, c, v, z);
    cmp("jam", r, c, v, z, 16'h2345, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("jam_no_second_done", 32'(bus.done), 32'd0);
      check("jam_idle", 32'(bus.busy), 32'd0);
    end
    bus.start = 1'b1;
    bus.a = 16'hABCD;
    bus.b = 16'h1111;
    bus.op = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    step();
    #1 reset = 1'b1;
    #1;
    check("amid_busy", 32'(bus.busy), 32'd0);
    check("amid_done", 32'(bus.done), 32'd0);
    cmp("amid", bus.result, bus.carry_out, bus.overflow, bus.zero, '0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    step();
    check("post_rst_idle", 32'(bus.busy), 32'd0);
    run_op(16'h0003, 16'h0003, 1'b1, 1'b0, r, c, v, z);
    cmp("post_rst", r, c, v, z, 16'h0000, 1'b1, 1'b0, 1'b1);
    hr = r;
    hc = c;
    hv = v;
    hz = z;
    for (int i = 0; i < 10; i++) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.op = 1'($urandom);
      step();
      cmp("hold", bus.result, bus.carry_out, bus.overflow, bus.zero, hr, hc, hv, hz);
      check("hold_done", 32'(bus.done), 32'd0);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, r, c, v, z);
    cmp("b2b0", r, c, v, z, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_op(16'h0100, 16'h0101, 1'b1, 1'b0, r, c, v, z);
    cmp("b2b1", r, c, v, z, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = (i % 4 == 0) ? ra : W'($urandom);
      ro = 1'($urandom);
      model(ra, rb, ro, er, ec, ev, ez);
      run_op(ra, rb, ro, 1'($urandom), r, c, v, z);
      cmp($sformatf("rand%0d", i), r, c, v, z, er, ec, ev, ez);
      for (int k = $urandom_range(0, 2); k > 0; k--) step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
